// File: rtl/cmos_pixel_capture.sv
// rtl/cmos_pixel_capture.sv - CMOS byte stream to RGB565 pixel source for the wfifo packer
//
// Purpose:
//   Pairs 8-bit sensor bytes into RGB565 words during href. Skips WAIT_FRAMES
//   frames after enable. Pulses wr_load at every captured-frame start and
//   frame_done at every frame close. Flags malformed lines/frames on frame_err.
//
// Optional feature macro: CMOS_TEST_PATTERN_EN
//   Adds test_mode. When test_mode=1, datain carries an 8-bar colour pattern
//   instead of cam_data.
//
// Ports:
//   wr_clk        in   1   pixel clock; all logic on its rising edge
//   rst_n         in   1   asynchronous active-low reset
//   capture_en    in   1   capture enable level (acted on at frame boundaries)
//   cam_vsync     in   1   frame sync, active high
//   cam_href      in   1   line valid, active high
//   cam_data      in   8   pixel byte, high byte first
//   test_mode     in   1   colour-bar source select (CMOS_TEST_PATTERN_EN only)
//   wr_load       out  1   1-cycle pulse at each captured-frame start
//   datain_valid  out  1   1-cycle strobe qualifying datain
//   datain        out  16  RGB565 pixel {first byte, second byte}
//   frame_done    out  1   1-cycle pulse when a captured frame closes
//   frame_err     out  1   sticky framing error, cleared by wr_load
//   frame_cnt     out  16  captured-frame counter, wraps

module cmos_pixel_capture #(
  parameter int WAIT_FRAMES = 10,
  parameter int H_PIXELS    = 640,
  parameter int V_LINES     = 480
) (
  input  logic        wr_clk,
  input  logic        rst_n,
  input  logic        capture_en,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
`ifdef CMOS_TEST_PATTERN_EN
  input  logic        test_mode,
`endif
  output logic        wr_load,
  output logic        datain_valid,
  output logic [15:0] datain,
  output logic        frame_done,
  output logic        frame_err,
  output logic [15:0] frame_cnt
);

  localparam logic [10:0] H_W    = 11'(H_PIXELS);
  localparam logic [9:0]  V_W    = 10'(V_LINES);
  localparam logic [15:0] WAIT_W = 16'(WAIT_FRAMES);

  typedef enum logic [1:0] {IDLE, STABLE, ARMED, CAPTURE} state_t;

  state_t      state;
  logic        vs_d0, vs_d1;
  logic        href_d0, href_d1;
  logic [7:0]  data_d0;
  logic        phase;
  logic [7:0]  hi_byte;
  logic [10:0] pix_cnt;
  logic [9:0]  line_cnt;
  logic [15:0] wait_cnt;
  logic        line_active;

  logic        vs_rise;
  logic        href_rise;
  logic        line_on;
  logic        line_end;
  logic        line_bad;
  logic [10:0] pix_inc;
  logic [9:0]  line_inc;
  logic [9:0]  lines_closed;
  logic [15:0] pix_word;

  assign vs_rise   = vs_d0 & ~vs_d1;
  assign href_rise = href_d0 & ~href_d1;

  // A line only opens on an href rising edge, so the tail of a line that was
  // cut short by vsync is not counted as a fresh line in the new frame.
  assign line_on  = href_d0 & (line_active | href_rise);
  // vsync arriving with href still high closes the line as if href fell.
  assign line_end = line_active & (~href_d0 | vs_rise);
  assign line_bad = (pix_cnt != H_W) | phase;

  assign pix_inc      = (pix_cnt == 11'h7FF) ? pix_cnt : pix_cnt + 11'd1;
  assign line_inc     = (line_cnt == 10'h3FF) ? line_cnt : line_cnt + 10'd1;
  assign lines_closed = line_end ? line_inc : line_cnt;

`ifdef CMOS_TEST_PATTERN_EN
  localparam logic [10:0] BAR_W = 11'(H_PIXELS / 8);
  logic [10:0] bar_idx;
  assign bar_idx = pix_cnt / BAR_W;

  always_comb begin
    pix_word = {hi_byte, data_d0};
    if (test_mode) begin
      case (bar_idx)
        11'd0:   pix_word = 16'hFFFF;
        11'd1:   pix_word = 16'hFFE0;
        11'd2:   pix_word = 16'h07FF;
        11'd3:   pix_word = 16'h07E0;
        11'd4:   pix_word = 16'hF81F;
        11'd5:   pix_word = 16'hF800;
        11'd6:   pix_word = 16'h001F;
        default: pix_word = 16'h0000;
      endcase
    end
  end
`else
  always_comb begin
    pix_word = {hi_byte, data_d0};
  end
`endif

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      vs_d0        <= 1'b0;
      vs_d1        <= 1'b0;
      href_d0      <= 1'b0;
      href_d1      <= 1'b0;
      data_d0      <= 8'd0;
      phase        <= 1'b0;
      hi_byte      <= 8'd0;
      pix_cnt      <= 11'd0;
      line_cnt     <= 10'd0;
      wait_cnt     <= 16'd0;
      line_active  <= 1'b0;
      wr_load      <= 1'b0;
      datain_valid <= 1'b0;
      datain       <= 16'd0;
      frame_done   <= 1'b0;
      frame_err    <= 1'b0;
      frame_cnt    <= 16'd0;
    end else begin
      vs_d0   <= cam_vsync;
      vs_d1   <= vs_d0;
      href_d0 <= cam_href;
      href_d1 <= href_d0;
      data_d0 <= cam_data;

      wr_load      <= 1'b0;
      datain_valid <= 1'b0;
      frame_done   <= 1'b0;

      case (state)
        IDLE: begin
          if (capture_en) begin
            state    <= STABLE;
            wait_cnt <= 16'd0;
          end
        end

        STABLE: begin
          if (!capture_en) begin
            state <= IDLE;
          end else if (wait_cnt >= WAIT_W) begin
            state <= ARMED;
          end else if (vs_rise) begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end

        ARMED: begin
          if (!capture_en) begin
            state <= IDLE;
          end else if (vs_rise) begin
            state       <= CAPTURE;
            wr_load     <= 1'b1;
            pix_cnt     <= 11'd0;
            line_cnt    <= 10'd0;
            phase       <= 1'b0;
            line_active <= 1'b0;
            frame_err   <= 1'b0;
          end
        end

        CAPTURE: begin
          if (line_end) begin
            line_active <= 1'b0;
            pix_cnt     <= 11'd0;
            line_cnt    <= line_inc;
            if (line_bad) frame_err <= 1'b1;
          end

          if (vs_rise) begin
            frame_done  <= 1'b1;
            frame_cnt   <= frame_cnt + 16'd1;
            phase       <= 1'b0;
            line_active <= 1'b0;
            pix_cnt     <= 11'd0;
            line_cnt    <= 10'd0;
            if (lines_closed != V_W) frame_err <= 1'b1;
            if (capture_en) begin
              // Back-to-back frame: the new frame's clear overrides any error
              // raised by the frame that just closed.
              wr_load   <= 1'b1;
              frame_err <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else if (line_on) begin
            line_active <= 1'b1;
            if (!phase) begin
              hi_byte <= data_d0;
              phase   <= 1'b1;
            end else begin
              datain       <= pix_word;
              datain_valid <= 1'b1;
              phase        <= 1'b0;
              pix_cnt      <= pix_inc;
            end
          end else begin
            phase <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmos_pixel_capture.sv
// tb/tb_cmos_pixel_capture.sv - directed self-checking bench for cmos_pixel_capture
module tb_cmos_pixel_capture;

  localparam int WF = 2;
  localparam int HP = 16;
  localparam int VL = 4;

  logic        wr_clk = 1'b0;
  logic        rst_n;
  logic        capture_en;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
`ifdef CMOS_TEST_PATTERN_EN
  logic        test_mode;
`endif
  logic        wr_load;
  logic        datain_valid;
  logic [15:0] datain;
  logic        frame_done;
  logic        frame_err;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  int vc = 0;
  int wl = 0;
  int fd = 0;
  int b2b = 0;
  logic prev_valid = 1'b0;
  logic [15:0] q[$];

  int vc_b;
  int wl_b;

  cmos_pixel_capture #(
    .WAIT_FRAMES(WF),
    .H_PIXELS(HP),
    .V_LINES(VL)
  ) dut (
    .wr_clk(wr_clk),
    .rst_n(rst_n),
    .capture_en(capture_en),
    .cam_vsync(cam_vsync),
    .cam_href(cam_href),
    .cam_data(cam_data),
`ifdef CMOS_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .wr_load(wr_load),
    .datain_valid(datain_valid),
    .datain(datain),
    .frame_done(frame_done),
    .frame_err(frame_err),
    .frame_cnt(frame_cnt)
  );

  always #5 wr_clk = ~wr_clk;

  always @(negedge wr_clk) begin
    if (datain_valid) begin
      vc++;
      q.push_back(datain);
      if (prev_valid) b2b++;
    end
    prev_valid = datain_valid;
    if (wr_load) wl++;
    if (frame_done) fd++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge wr_clk);
  endtask

  task automatic vsync_pulse();
    cam_vsync = 1'b1;
    idle(3);
    cam_vsync = 1'b0;
    idle(3);
  endtask

  task automatic send_line(input int nbytes, input logic [7:0] seed);
    for (int i = 0; i < nbytes; i++) begin
      cam_href = 1'b1;
      cam_data = seed + 8'(i);
      @(negedge wr_clk);
    end
    cam_href = 1'b0;
    cam_data = 8'h00;
    idle(4);
  endtask

  task automatic send_lines(input int n);
    for (int l = 0; l < n; l++) send_line(2 * HP, 8'(16 * l + 1));
  endtask

  initial begin
    rst_n      = 1'b0;
    capture_en = 1'b0;
    cam_vsync  = 1'b0;
    cam_href   = 1'b0;
    cam_data   = 8'h00;
`ifdef CMOS_TEST_PATTERN_EN
    test_mode  = 1'b0;
`endif
    idle(2);
    check("reset_wr_load", wr_load, 0);
    check("reset_valid", datain_valid, 0);
    check("reset_datain", datain, 0);
    check("reset_frame_done", frame_done, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_frame_cnt", frame_cnt, 0);
    rst_n = 1'b1;
    idle(2);

    // Two discarded frames, then arming on the third vsync
    capture_en = 1'b1;
    idle(2);
    vsync_pulse();
    send_lines(VL);
    vsync_pulse();
    send_lines(VL);
    check("discard_wr_load", wl, 0);
    check("discard_strobes", vc, 0);
    vsync_pulse();
    check("first_wr_load", wl, 1);
    check("first_no_done", fd, 0);

    // Byte pairing latency on the first line of the captured frame
    cam_href = 1'b1;
    cam_data = 8'h12;
    @(negedge wr_clk);
    cam_data = 8'h34;
    @(negedge wr_clk);
    check("lat_valid_early", datain_valid, 0);
    cam_data = 8'h56;
    @(negedge wr_clk);
    check("lat_valid_1", datain_valid, 1);
    check("lat_data_1", datain, 16'h1234);
    cam_data = 8'h78;
    @(negedge wr_clk);
    check("lat_valid_gap", datain_valid, 0);
    cam_data = 8'h9A;
    @(negedge wr_clk);
    check("lat_valid_2", datain_valid, 1);
    check("lat_data_2", datain, 16'h5678);
    for (int i = 5; i < 2 * HP; i++) begin
      cam_data = 8'(i);
      @(negedge wr_clk);
    end
    cam_href = 1'b0;
    cam_data = 8'h00;
    idle(4);
    send_lines(VL - 1);
    check("frame3_strobes", vc, HP * VL);
    check("frame3_err", frame_err, 0);
    vsync_pulse();
    check("frame3_done", fd, 1);
    check("frame3_cnt", frame_cnt, 1);
    check("frame4_wr_load", wl, 2);
    send_lines(VL);
    vsync_pulse();
    check("frame4_cnt", frame_cnt, 2);
    check("frame4_err", frame_err, 0);

    // Short line (one pixel missing)
    send_line(2 * HP - 2, 8'h40);
    check("short_line_err", frame_err, 1);
    send_lines(VL - 1);
    check("short_err_sticky", frame_err, 1);
    vsync_pulse();
    check("short_err_cleared", frame_err, 0);
    check("short_done", fd, 3);

    // Line with one odd trailing byte
    vc_b = vc;
    send_line(2 * HP + 1, 8'hA0);
    check("odd_strobes", vc - vc_b, HP);
    check("odd_last_word", datain, 16'hBEBF);
    check("odd_err", frame_err, 1);
    send_lines(VL - 1);
    vsync_pulse();
    check("odd_frame_cnt", frame_cnt, 4);

    // capture_en dropped mid-frame: frame completes, then idle
    vc_b = vc;
    wl_b = wl;
    send_line(2 * HP, 8'h01);
    capture_en = 1'b0;
    send_lines(VL - 1);
    check("drop_strobes", vc - vc_b, HP * VL);
    vsync_pulse();
    check("drop_frame_cnt", frame_cnt, 5);
    check("drop_done", fd, 5);
    check("drop_no_wr_load", wl - wl_b, 0);
    check("drop_err", frame_err, 0);
    send_lines(VL);
    vsync_pulse();
    check("idle_strobes", vc - vc_b, HP * VL);
    check("idle_wr_load", wl - wl_b, 0);
    check("idle_frame_cnt", frame_cnt, 5);

    // Asynchronous reset mid-line
    capture_en = 1'b1;
    idle(2);
    cam_href = 1'b1;
    cam_data = 8'h55;
    idle(3);
    #2 rst_n = 1'b0;
    #1;
    check("async_frame_cnt", frame_cnt, 0);
    check("async_datain", datain, 0);
    check("async_valid", datain_valid, 0);
    check("async_err", frame_err, 0);
    @(negedge wr_clk);
    cam_href = 1'b0;
    cam_data = 8'h00;
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Discard restarts after reset
    vc_b = vc;
    wl_b = wl;
    vsync_pulse();
    send_lines(VL);
    vsync_pulse();
    send_lines(VL);
    check("rediscard_strobes", vc - vc_b, 0);
    check("rediscard_wr_load", wl - wl_b, 0);
    vsync_pulse();
    check("rearm_wr_load", wl - wl_b, 1);

`ifdef CMOS_TEST_PATTERN_EN
    test_mode = 1'b1;
`endif
    q.delete();
    send_line(2 * HP, 8'h20);
    check("last_line_count", q.size(), HP);
`ifdef CMOS_TEST_PATTERN_EN
    check("bar_pixel_0", q[0], 16'hFFFF);
    check("bar_pixel_1st_bar", q[HP / 8], 16'hFFE0);
    check("bar_pixel_last", q[HP - 1], 16'h0000);
`else
    check("cam_pixel_0", q[0], 16'h2021);
    check("cam_pixel_last", q[HP - 1], 16'h3E3F);
`endif
    check("no_back_to_back", b2b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
